// File: rtl/trigger_delay_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module : trigger_delay_ctrl_mc
// Brief  : UART byte-command controller for NUM_CH trigger-delay channels
//          (delays, edges, trigger counters, readbacks). Define CMD_TIMEOUT_EN
//          to abort partial frames after TIMEOUT_CYC idle cycles.
// Rev    : 1.0  initial release
// ============================================================================
module trigger_delay_ctrl_mc #(
  parameter int NUM_CH      = 4,
  parameter int COARSE_W    = 32,
  parameter int FINE_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  input  logic                       tx_ready,
  input  logic [NUM_CH-1:0]          trig_pulse,
  output logic [NUM_CH*COARSE_W-1:0] coarse_delay,
  output logic [NUM_CH-1:0]          coarse_update,
  output logic [NUM_CH*FINE_W-1:0]   fine_delay,
  output logic [NUM_CH-1:0]          fine_update,
  output logic [NUM_CH*2-1:0]        edge_type,
  output logic                       busy
);

  localparam int         CH_IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         PAY_W      = (COARSE_W > FINE_W) ? COARSE_W : FINE_W;
  localparam int         RESP_W     = CNT_W + COARSE_W + FINE_W;
  localparam logic [7:0] C_NUM_CH   = 8'(NUM_CH);
  localparam logic [1:0] C_CRS_LAST = 2'(COARSE_W / 8 - 1);
  localparam logic [1:0] C_FIN_LAST = 2'(FINE_W / 8 - 1);
  localparam logic [3:0] C_CRS_LEN  = 4'(COARSE_W / 8);
  localparam logic [3:0] C_FIN_LEN  = 4'(FINE_W / 8);
  localparam logic [3:0] C_STAT_LEN = 4'(RESP_W / 8);

  localparam logic [7:0] C_OP_SET_COARSE  = 8'h01;
  localparam logic [7:0] C_OP_GET_COARSE  = 8'h02;
  localparam logic [7:0] C_OP_SET_EDGE    = 8'h03;
  localparam logic [7:0] C_OP_GET_EDGE    = 8'h04;
  localparam logic [7:0] C_OP_GET_STATUS  = 8'h05;
  localparam logic [7:0] C_OP_RESET_COUNT = 8'h06;
  localparam logic [7:0] C_OP_SET_FINE    = 8'h07;
  localparam logic [7:0] C_OP_GET_FINE    = 8'h08;
  localparam logic [7:0] C_OP_GET_INFO    = 8'h09;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHAN    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_APPLY   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d, chan_q, chan_d;
  logic [PAY_W-1:0]    pay_q, pay_d;
  logic [1:0]          pidx_q, pidx_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [3:0]          rlen_q, rlen_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;

  logic [COARSE_W-1:0] coarse_q [NUM_CH];
  logic [FINE_W-1:0]   fine_q   [NUM_CH];
  logic [1:0]          edge_q   [NUM_CH];
  logic [CNT_W-1:0]    cnt_q    [NUM_CH];

  logic [PAY_W-1:0]    w_pay_full;
  logic [1:0]          w_last;
  logic                w_load;
  logic [NUM_CH-1:0]   w_mask;
  logic [NUM_CH-1:0]   w_clr;
  logic [1:0]          w_edge_new;
  logic                w_ch_ok;
  logic [CH_IW-1:0]    w_ch_idx;
  logic [RESP_W-1:0]   w_resp;
  logic [3:0]          w_rlen;
  logic                w_timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q;
  logic            w_wait_st;

  assign w_wait_st = (state_q == S_CHAN) || (state_q == S_PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst || rx_valid || !w_wait_st) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + TO_W'(1);
    end
  end

  assign w_timeout = w_wait_st && !rx_valid && (to_q == TO_W'(TIMEOUT_CYC - 1));
`else
  // Feature disabled: the limit is accepted but can never fire.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  // Response image is captured from the channel byte itself, so the first
  // TX byte can go out right after CHAN.
  always_comb begin
    w_ch_ok  = (rx_data < C_NUM_CH);
    w_ch_idx = w_ch_ok ? rx_data[CH_IW-1:0] : '0;
    w_resp   = RESP_W'(8'hEE);
    w_rlen   = 4'd1;
    if (op_q == C_OP_GET_INFO) begin
      w_resp = RESP_W'(C_NUM_CH);
    end else if (w_ch_ok) begin
      case (op_q)
        C_OP_GET_COARSE: begin
          w_resp = RESP_W'(coarse_q[w_ch_idx]);
          w_rlen = C_CRS_LEN;
        end
        C_OP_GET_EDGE:   w_resp = RESP_W'(edge_q[w_ch_idx]);
        C_OP_GET_STATUS: begin
          w_resp = {fine_q[w_ch_idx], coarse_q[w_ch_idx], cnt_q[w_ch_idx]};
          w_rlen = C_STAT_LEN;
        end
        C_OP_GET_FINE: begin
          w_resp = RESP_W'(fine_q[w_ch_idx]);
          w_rlen = C_FIN_LEN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pay_full = pay_q;
    w_pay_full[{pidx_q, 3'b000} +: 8] = rx_data;
    w_edge_new = (w_pay_full[7:0] > 8'd3) ? 2'b01 : w_pay_full[1:0];
    case (op_q)
      C_OP_SET_COARSE: w_last = C_CRS_LAST;
      C_OP_SET_FINE:   w_last = C_FIN_LAST;
      default:         w_last = 2'd0;
    endcase
  end

  always_comb begin
    w_mask = '0;
    if (chan_q == 8'hFF) begin
      w_mask = '1;
    end else if (chan_q < C_NUM_CH) begin
      w_mask[chan_q[CH_IW-1:0]] = 1'b1;
    end
  end

  assign w_clr         = (state_q == S_APPLY && op_q == C_OP_RESET_COUNT) ? w_mask : '0;
  assign coarse_update = (state_q == S_APPLY && op_q == C_OP_SET_COARSE)  ? w_mask : '0;
  assign fine_update   = (state_q == S_APPLY && op_q == C_OP_SET_FINE)    ? w_mask : '0;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    chan_d    = chan_q;
    pay_d     = pay_q;
    pidx_d    = pidx_q;
    resp_d    = resp_q;
    rlen_d    = rlen_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    w_load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data >= C_OP_SET_COARSE && rx_data <= C_OP_GET_INFO) begin
          op_d    = rx_data;
          state_d = S_CHAN;
        end
      end
      S_CHAN: begin
        if (rx_valid) begin
          chan_d = rx_data;
          pay_d  = '0;
          pidx_d = '0;
          case (op_q)
            C_OP_SET_COARSE, C_OP_SET_EDGE, C_OP_SET_FINE: state_d = S_PAYLOAD;
            C_OP_RESET_COUNT: state_d = S_APPLY;
            default: begin
              state_d = S_RESP;
              resp_d  = w_resp;
              rlen_d  = w_rlen;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          pay_d  = w_pay_full;
          pidx_d = pidx_q + 2'd1;
          if (pidx_q == w_last) begin
            state_d = S_APPLY;
            w_load  = 1'b1;
          end
        end
      end
      S_APPLY: state_d = S_IDLE;
      S_RESP: begin
        // The cycle after a strobe never issues, covering UART ready lag.
        if (tx_en_q && rlen_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (!tx_en_q && tx_ready && rlen_q != 4'd0) begin
          tx_en_d   = 1'b1;
          tx_data_d = resp_q[7:0];
          resp_d    = resp_q >> 8;
          rlen_d    = rlen_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_timeout) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      chan_q    <= '0;
      pay_q     <= '0;
      pidx_q    <= '0;
      resp_q    <= '0;
      rlen_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      chan_q    <= chan_d;
      pay_q     <= pay_d;
      pidx_q    <= pidx_d;
      resp_q    <= resp_d;
      rlen_q    <= rlen_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Settings load on the edge into APPLY so they are visible with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        coarse_q[i] <= '0;
        fine_q[i]   <= '0;
        edge_q[i]   <= 2'b01;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_load && w_mask[i]) begin
          case (op_q)
            C_OP_SET_COARSE: coarse_q[i] <= w_pay_full[COARSE_W-1:0];
            C_OP_SET_FINE:   fine_q[i]   <= w_pay_full[FINE_W-1:0];
            C_OP_SET_EDGE:   edge_q[i]   <= w_edge_new;
            default: ;
          endcase
        end
        if (w_clr[i]) begin
          cnt_q[i] <= '0;
        end else if (trig_pulse[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign coarse_delay[g*COARSE_W +: COARSE_W] = coarse_q[g];
      assign fine_delay[g*FINE_W +: FINE_W]       = fine_q[g];
      assign edge_type[g*2 +: 2]                  = edge_q[g];
    end
  endgenerate

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trigger_delay_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_trigger_delay_ctrl_mc
// Brief  : Directed self-checking bench for trigger_delay_ctrl_mc.
// Rev    : 1.0  initial release
// ============================================================================
module tb_trigger_delay_ctrl_mc;

  localparam int NUM_CH      = 4;
  localparam int COARSE_W    = 32;
  localparam int FINE_W      = 16;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT_CYC = 100;

  typedef logic [7:0] bq_t[$];

  logic                       clk = 1'b0;
  logic                       rst;
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic [7:0]                 tx_data;
  logic                       tx_en;
  logic                       tx_ready;
  logic [NUM_CH-1:0]          trig_pulse;
  logic [NUM_CH*COARSE_W-1:0] coarse_delay;
  logic [NUM_CH-1:0]          coarse_update;
  logic [NUM_CH*FINE_W-1:0]   fine_delay;
  logic [NUM_CH-1:0]          fine_update;
  logic [NUM_CH*2-1:0]        edge_type;
  logic                       busy;

  always #5 clk = ~clk;

  trigger_delay_ctrl_mc #(
    .NUM_CH(NUM_CH), .COARSE_W(COARSE_W), .FINE_W(FINE_W),
    .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_en(tx_en), .tx_ready(tx_ready),
    .trig_pulse(trig_pulse), .coarse_delay(coarse_delay),
    .coarse_update(coarse_update), .fine_delay(fine_delay),
    .fine_update(fine_update), .edge_type(edge_type), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: per-channel settings, counts and expected strobes.
  logic [COARSE_W-1:0] m_coarse [NUM_CH];
  logic [FINE_W-1:0]   m_fine   [NUM_CH];
  logic [1:0]          m_edge   [NUM_CH];
  int                  m_cnt    [NUM_CH];
  logic [NUM_CH-1:0]   e_cup, e_fup;
  bit                  chk_en = 1'b0;
  bq_t                 rxq, got;
  logic                prev_en = 1'b0, prev_rdy = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*COARSE_W-1:0] pack_coarse();
    logic [NUM_CH*COARSE_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*COARSE_W +: COARSE_W] = m_coarse[i];
    return v;
  endfunction

  function automatic logic [NUM_CH*FINE_W-1:0] pack_fine();
    logic [NUM_CH*FINE_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*FINE_W +: FINE_W] = m_fine[i];
    return v;
  endfunction

  function automatic logic [NUM_CH*2-1:0] pack_edge();
    logic [NUM_CH*2-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*2 +: 2] = m_edge[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_coarse[i] = '0;
      m_fine[i]   = '0;
      m_edge[i]   = 2'b01;
      m_cnt[i]    = 0;
    end
    e_cup = '0;
    e_fup = '0;
  endtask

  // Applies a command's effect; called in the cycle the DUT should be in APPLY.
  task automatic model_apply(input logic [7:0] op, input logic [7:0] ch, input logic [31:0] val);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 8'hFF || ch == 8'(i)) begin
        case (op)
          8'h01: begin m_coarse[i] = COARSE_W'(val); e_cup[i] = 1'b1; end
          8'h07: begin m_fine[i] = FINE_W'(val); e_fup[i] = 1'b1; end
          8'h03: m_edge[i] = (val[7:0] > 8'd3) ? 2'b01 : val[1:0];
          8'h06: m_cnt[i] = 0;
          default: ;
        endcase
      end
    end
  endtask

  function automatic bq_t model_resp(input logic [7:0] op, input logic [7:0] ch);
    bq_t q;
    q = {};
    if (op == 8'h09) begin
      q.push_back(8'(NUM_CH));
    end else if (ch >= 8'(NUM_CH)) begin
      q.push_back(8'hEE);
    end else begin
      if (op == 8'h05)
        for (int b = 0; b < CNT_W / 8; b++) q.push_back(8'(m_cnt[ch] >> (8 * b)));
      if (op == 8'h02 || op == 8'h05)
        for (int b = 0; b < COARSE_W / 8; b++) q.push_back(8'(m_coarse[ch] >> (8 * b)));
      if (op == 8'h08 || op == 8'h05)
        for (int b = 0; b < FINE_W / 8; b++) q.push_back(8'(m_fine[ch] >> (8 * b)));
      if (op == 8'h04) q.push_back(8'(m_edge[ch]));
    end
    return q;
  endfunction

  // Compare process: outputs against the model every cycle, plus TX capture.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("coarse_delay", 128'(coarse_delay), 128'(pack_coarse()));
      chk("fine_delay", 128'(fine_delay), 128'(pack_fine()));
      chk("edge_type", 128'(edge_type), 128'(pack_edge()));
      chk("coarse_update", 128'(coarse_update), 128'(e_cup));
      chk("fine_update", 128'(fine_update), 128'(e_fup));
    end
    if (!rst && tx_en) begin
      rxq.push_back(tx_data);
      chk("tx_en_one_cycle", 128'(prev_en), 128'(0));
      chk("tx_ready_before_en", 128'(prev_rdy), 128'(1));
    end
    prev_en  = tx_en;
    prev_rdy = tx_ready;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic set_frame(input logic [7:0] op, input logic [7:0] ch, input logic [31:0] val, input int nb);
    send_byte(op);
    send_byte(ch);
    for (int b = 0; b < nb; b++) send_byte(8'(val >> (8 * b)));
    model_apply(op, ch, val);
    @(posedge clk); #1;
    e_cup = '0;
    e_fup = '0;
  endtask

  task automatic pulse(input int ch);
    trig_pulse[ch] = 1'b1;
    @(posedge clk); #1;
    trig_pulse = '0;
    m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CNT_W);
  endtask

  task automatic cmp_bytes(input string nm, input bq_t exp);
    chk({nm, "_len"}, 128'(got.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk({nm, "_byte"}, 128'(got[i]), 128'(exp[i]));
  endtask

  task automatic collect(input int n);
    int cyc;
    cyc = 0;
    while (rxq.size() < n && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) begin @(posedge clk); #1; end
    got = rxq;
  endtask

  task automatic get_frame(input logic [7:0] op, input logic [7:0] ch, input string nm);
    bq_t exp;
    exp = model_resp(op, ch);
    rxq.delete();
    send_byte(op);
    send_byte(ch);
    collect(exp.size());
    cmp_bytes(nm, exp);
    chk({nm, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    bq_t lit, exp;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1; trig_pulse = '0; rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_tx_en", 128'(tx_en), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_coarse", 128'(coarse_delay), 128'(0));
    chk("rst_fine", 128'(fine_delay), 128'(0));
    chk("rst_edge", 128'(edge_type), 128'(8'h55));
    chk("rst_strobes", 128'({coarse_update, fine_update}), 128'(0));
    chk_en = 1'b1;

    set_frame(8'h01, 8'h00, 32'h12345678, 4);
    chk("coarse_ch0_lit", 128'(coarse_delay[31:0]), 128'(32'h12345678));
    get_frame(8'h02, 8'h00, "get_coarse0");
    lit = {8'h78, 8'h56, 8'h34, 8'h12};
    cmp_bytes("get_coarse0_lit", lit);

    repeat (3) pulse(1);
    get_frame(8'h05, 8'h01, "status1");
    lit = {8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cmp_bytes("status1_lit", lit);

    // RESET_COUNT with a trigger pulse in the APPLY cycle: reset wins.
    send_byte(8'h06);
    send_byte(8'h01);
    trig_pulse[1] = 1'b1;
    model_apply(8'h06, 8'h01, 32'h0);
    @(posedge clk); #1;
    trig_pulse = '0;
    get_frame(8'h05, 8'h01, "status1_clr");
    lit = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cmp_bytes("status1_clr_lit", lit);

    set_frame(8'h07, 8'hFF, 32'h2710, 2);
    chk("fine_bcast_lit", 128'(fine_delay), 128'({4{16'h2710}}));
    get_frame(8'h08, 8'h03, "get_fine3");
    lit = {8'h10, 8'h27};
    cmp_bytes("get_fine3_lit", lit);

    set_frame(8'h03, 8'h02, 32'h07, 1);
    chk("edge_map_lit", 128'(edge_type[5:4]), 128'(2'b01));
    set_frame(8'h03, 8'h02, 32'h02, 1);
    get_frame(8'h04, 8'h02, "get_edge2");
    lit = {8'h02};
    cmp_bytes("get_edge2_lit", lit);
    get_frame(8'h02, 8'h09, "get_invalid");
    lit = {8'hEE};
    cmp_bytes("get_invalid_lit", lit);
    get_frame(8'h04, 8'hFF, "get_bcast");

    set_frame(8'h01, 8'h09, 32'h44332211, 4);   // invalid channel: no effect
    send_byte(8'h0A);                           // unknown opcode, discarded
    get_frame(8'h09, 8'h37, "get_info");
    lit = {8'h04};
    cmp_bytes("get_info_lit", lit);

    pulse(0); pulse(0); pulse(3);
    set_frame(8'h06, 8'hFF, 32'h0, 0);
    get_frame(8'h05, 8'h03, "status3_bclr");

    // Hold tx_ready low through a status readback.
    tx_ready = 1'b0;
    rxq.delete();
    exp = model_resp(8'h05, 8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    repeat (50) begin @(posedge clk); #1; end
    chk("stall_no_tx", 128'(rxq.size()), 128'(0));
    chk("stall_busy", 128'(busy), 128'(1));
    tx_ready = 1'b1;
    collect(exp.size());
    cmp_bytes("stall_status", exp);
    chk("stall_idle", 128'(busy), 128'(0));

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    repeat (TIMEOUT_CYC) @(posedge clk);
    #1;
`ifdef CMD_TIMEOUT_EN
    chk("timeout_idle", 128'(busy), 128'(0));
`else
    chk("wait_busy", 128'(busy), 128'(1));
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    model_apply(8'h01, 8'h00, 32'hDDCCBBAA);
    @(posedge clk); #1;
    e_cup = '0;
    chk("late_coarse_lit", 128'(coarse_delay[31:0]), 128'(32'hDDCCBBAA));
`endif
    get_frame(8'h09, 8'h00, "info_after");
    lit = {8'h04};
    cmp_bytes("info_after_lit", lit);

    // Reset in the middle of a SET_COARSE frame.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_edge", 128'(edge_type), 128'(8'h55));
    get_frame(8'h02, 8'h02, "midrst_coarse2");
    lit = {8'h00, 8'h00, 8'h00, 8'h00};
    cmp_bytes("midrst_coarse2_lit", lit);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trigger_delay_ctrl_mc.md
# trigger_delay_ctrl_mc

- Byte-stream command controller for the multi-channel trigger-delay unit.
- Decodes UART bytes into per-channel coarse delay, fine delay and edge settings for `NUM_CH` delay channels.
- Counts qualified trigger pulses per channel and returns readbacks over the UART TX byte interface.
- Sits between `UART_RX`/`UART_TX` and the channel delay instances; generalises the single-channel controller with channel addressing, broadcast writes, parametrised widths and a payload timeout.

## Interface
Parameters:
- `NUM_CH`, 4, number of delay channels (1..254).
- `COARSE_W`, 32, coarse delay width in clk cycles (8..32, multiple of 8).
- `FINE_W`, 16, fine delay width in ps (8..16, multiple of 8).
- `CNT_W`, 16, trigger counter width (8..32, multiple of 8).
- `TIMEOUT_CYC`, 1_000_000, payload inactivity limit in clk cycles; used only with `CMD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset `rst`, synchronous, active-high; clock `clk`.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `tx_data`  out  8  byte to transmit.
- `tx_en`  out  1  one-cycle transmit strobe.
- `tx_ready`  in  1  UART TX idle.
- `trig_pulse`  in  NUM_CH  per-channel single-cycle edge pulses, already synchronised.
- `coarse_delay`  out  NUM_CH*COARSE_W  packed; channel i at `[i*COARSE_W +: COARSE_W]`.
- `coarse_update`  out  NUM_CH  one-cycle load strobe per channel.
- `fine_delay`  out  NUM_CH*FINE_W  packed, same layout as `coarse_delay`.
- `fine_update`  out  NUM_CH  one-cycle load strobe per channel.
- `edge_type`  out  NUM_CH*2  packed; 00 none, 01 rising, 10 falling, 11 both.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format: opcode, channel byte, payload (little-endian).
- Opcodes:
  - 0x01 SET_COARSE: COARSE_W/8 payload bytes.
  - 0x02 GET_COARSE: no payload; responds with coarse value.
  - 0x03 SET_EDGE: 1 payload byte.
  - 0x04 GET_EDGE: no payload; responds with 1 byte.
  - 0x05 GET_STATUS: no payload; responds with count, then coarse, then fine.
  - 0x06 RESET_COUNT: no payload.
  - 0x07 SET_FINE: FINE_W/8 payload bytes.
  - 0x08 GET_FINE: no payload; responds with fine value.
  - 0x09 GET_INFO: channel byte is ignored; responds with 1 byte = NUM_CH.
- Unknown opcode: discarded in IDLE; no channel byte is consumed.
- FSM states: IDLE → CHAN → (PAYLOAD) → APPLY or RESP → IDLE.
  - IDLE: the opcode byte moves the FSM to CHAN.
  - CHAN: the next byte is latched as the channel.
  - PAYLOAD: collects the payload bytes.
  - APPLY: lasts one cycle.
  - RESP: sends the response bytes.
- Channel 0xFF = broadcast.
  - Valid for SET_* and RESET_COUNT: applies to all channels in the same APPLY cycle.
  - For GET_*: treated as an invalid channel.
- Invalid channel (≥NUM_CH and not broadcast):
  - SET: payload is consumed and discarded; no strobe.
  - GET: responds with the single byte 0xEE.
- SET_EDGE payload: 0x00–0x03 map directly; any other value → 01.
- Counters: each channel increments by 1 on `trig_pulse[i]` and wraps 2^CNT_W−1 → 0, independent of FSM state.
  - If RESET_COUNT APPLY and `trig_pulse` coincide, the counter becomes 0 (reset wins).
- `current` readback values are the registered outputs themselves.
- Reset values:
  - All delays 0; all counters 0; `edge_type` = 01 per channel.
  - All strobes 0; `tx_en` 0; `tx_data` 0x00; `busy` 0; FSM in IDLE.

## Timing
- `rx_valid` is accepted in any cycle of CHAN/PAYLOAD. Bytes arriving during RESP/APPLY are dropped.
- APPLY occurs the cycle after the final payload byte's `rx_valid`.
  - In APPLY, `coarse_delay`/`fine_delay`/`edge_type` take their new value.
  - In the same cycle, the matching `*_update` bit(s) are high for exactly that one cycle.
- RESP byte handshake: a byte is issued when `tx_ready` = 1 by driving `tx_data` and `tx_en` = 1 for one cycle.
  - `tx_ready` is ignored in the cycle following `tx_en`, which covers UART ready lag.
- The first response byte can issue at earliest the cycle after the channel byte.
- IDLE is re-entered the cycle after the last `tx_en` or after APPLY.
- A `rst` pulse mid-frame aborts the frame: no strobe, and any pending response is truncated.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - In CHAN or PAYLOAD, a cycle counter restarts on every `rx_valid`.
  - Reaching `TIMEOUT_CYC` without `rx_valid` returns the FSM to IDLE, discarding partial data with no strobe.
- `CMD_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely for bytes.

## Test plan
- 01 00 78 56 34 12 → `coarse_delay[31:0]`=0x12345678, `coarse_update`=0001 for one cycle; then 02 00 → TX 78 56 34 12.
- 07 FF 10 27 → all four `fine_delay` = 10000 and `fine_update`=1111 in one cycle; then 08 03 → TX 10 27.
- 03 02 07 → `edge_type` ch2 = 01; then 03 02 02, 04 02 → TX 02; 02 09 (invalid channel) → TX EE.
- Channel 1: 3 `trig_pulse[1]` pulses, then 05 01 → TX 03 00 00 00 00 00 00 00; 06 01 with a coincident pulse → count 0.
- With `CMD_TIMEOUT_EN`, TIMEOUT_CYC=100: send 01 00 AA, wait 100 cycles → FSM in IDLE, `busy`=0, no strobe; then 09 00 → TX 04.
- Hold `tx_ready` low for 50 cycles during GET_STATUS → no `tx_en`; release → 8 bytes, each `tx_en` one cycle wide.
